// File: rtl/sb_pkg.sv
// Shared types and defaults for the decode-stage hazard scoreboard.
package sb_pkg;

    localparam int SB_REGNOBITS = 5;
    localparam int SB_CNTBITS   = 2;
    localparam int SB_CNT_MAX   = (2 ** SB_CNTBITS) - 1;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        CTRL_WAIT = 1'b1
    } sb_state_e;

    // A pending source blocks issue unless its only outstanding write retires this cycle.
    function automatic logic src_hazard(
        input logic used,
        input logic reg_nonzero,
        input logic cnt_nonzero,
        input logic cnt_is_one,
        input logic wb_match
    );
        return used && reg_nonzero && cnt_nonzero && !(cnt_is_one && wb_match);
    endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Saturating up/down pending-write counter for one tracked resource.
module sb_reg_counter
    import sb_pkg::*;
#(
    parameter int CNTBITS = SB_CNTBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [CNTBITS-1:0] cnt,
    output logic               underflow
);

    localparam logic [CNTBITS-1:0] CNT_ZERO = {CNTBITS{1'b0}};
    localparam logic [CNTBITS-1:0] CNT_ONE  = CNTBITS'(1);
    localparam logic [CNTBITS-1:0] CNT_MAX  = {CNTBITS{1'b1}};

    logic [CNTBITS-1:0] cnt_q;
    logic [CNTBITS-1:0] cnt_d;

    // Next count: simultaneous inc and dec cancel; clamp at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (dec && !inc) begin
            if (cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A retire with nothing outstanding is a bookkeeping error.
    assign underflow = dec && (cnt_q == CNT_ZERO);
    assign cnt       = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: per-register pending counters plus control-transfer fetch hold.
// Optional CSR tracking is enabled by defining SB_CSR_TRACK_EN.
module hazard_scoreboard
    import sb_pkg::*;
#(
    parameter int REGNOBITS = SB_REGNOBITS,
    parameter int CNTBITS   = SB_CNTBITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      de_valid,
    input  logic [REGNOBITS-1:0]      de_rs1,
    input  logic [REGNOBITS-1:0]      de_rs2,
    input  logic                      de_rs1_used,
    input  logic                      de_rs2_used,
    input  logic                      de_wr_reg,
    input  logic [REGNOBITS-1:0]      de_rd,
    input  logic                      de_is_ctrl,
    input  logic                      agex_ctrl_resolved,
    input  logic                      wb_wr_reg,
    input  logic [REGNOBITS-1:0]      wb_rd,
`ifdef SB_CSR_TRACK_EN
    input  logic                      de_csr_rd,
    input  logic                      de_csr_wr,
    input  logic                      wb_wr_csr,
`endif
    output logic                      issue,
    output logic                      stall_de,
    output logic                      stall_fe,
    output logic [(2**REGNOBITS)-1:0] busy_vec,
    output logic                      sb_err
);

    localparam int NREGS = 2 ** REGNOBITS;
    localparam logic [CNTBITS-1:0]   CNT_ZERO = {CNTBITS{1'b0}};
    localparam logic [CNTBITS-1:0]   CNT_ONE  = CNTBITS'(1);
    localparam logic [CNTBITS-1:0]   CNT_MAX  = {CNTBITS{1'b1}};
    localparam logic [REGNOBITS-1:0] REG_ZERO = {REGNOBITS{1'b0}};

    logic [CNTBITS-1:0] cnt_s [NREGS];
    logic [NREGS-1:0]   uflow_s;
    logic               issue_s;
    logic               haz_rs1_s;
    logic               haz_rs2_s;
    logic               struct_s;
    logic               csr_haz_s;
    logic               csr_struct_s;
    logic               csr_uflow_s;
    sb_state_e          state_q;
    sb_state_e          state_d;
    logic               sb_err_q;

    // x0 is hard-wired: never pending, never in error.
    assign cnt_s[0]   = CNT_ZERO;
    assign uflow_s[0] = 1'b0;

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_cnt
            sb_reg_counter #(
                .CNTBITS (CNTBITS)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (issue_s && de_wr_reg && (de_rd == REGNOBITS'(i))),
                .dec       (wb_wr_reg && (wb_rd == REGNOBITS'(i))),
                .cnt       (cnt_s[i]),
                .underflow (uflow_s[i])
            );
        end
    endgenerate

`ifdef SB_CSR_TRACK_EN
    logic [CNTBITS-1:0] csr_cnt_s;

    sb_reg_counter #(
        .CNTBITS (CNTBITS)
    ) u_csr_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (issue_s && de_csr_wr),
        .dec       (wb_wr_csr),
        .cnt       (csr_cnt_s),
        .underflow (csr_uflow_s)
    );

    assign csr_haz_s    = src_hazard(de_csr_rd, 1'b1, csr_cnt_s != CNT_ZERO,
                                     csr_cnt_s == CNT_ONE, wb_wr_csr);
    assign csr_struct_s = de_csr_wr && (csr_cnt_s == CNT_MAX);
`else
    assign csr_haz_s    = 1'b0;
    assign csr_struct_s = 1'b0;
    assign csr_uflow_s  = 1'b0;
`endif

    // WB writes the register file on negedge, so a same-cycle retire of the last write is safe.
    assign haz_rs1_s = src_hazard(de_rs1_used, de_rs1 != REG_ZERO, cnt_s[de_rs1] != CNT_ZERO,
                                  cnt_s[de_rs1] == CNT_ONE, wb_wr_reg && (wb_rd == de_rs1));
    assign haz_rs2_s = src_hazard(de_rs2_used, de_rs2 != REG_ZERO, cnt_s[de_rs2] != CNT_ZERO,
                                  cnt_s[de_rs2] == CNT_ONE, wb_wr_reg && (wb_rd == de_rs2));
    assign struct_s  = de_wr_reg && (de_rd != REG_ZERO) && (cnt_s[de_rd] == CNT_MAX);

    assign issue_s  = de_valid && (state_q == IDLE) && !haz_rs1_s && !haz_rs2_s
                      && !struct_s && !csr_haz_s && !csr_struct_s;
    assign issue    = issue_s;
    assign stall_de = de_valid && !issue_s;
    assign stall_fe = stall_de || (state_q == CTRL_WAIT) || (issue_s && de_is_ctrl);
    assign sb_err   = sb_err_q;

    // Control-transfer hold: the resolve pulse only matters while waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_s && de_is_ctrl) begin
                    state_d = CTRL_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            CTRL_WAIT: begin
                if (agex_ctrl_resolved) begin
                    state_d = IDLE;
                end else begin
                    state_d = CTRL_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else if ((|uflow_s) || csr_uflow_s) begin
            sb_err_q <= 1'b1;
        end else begin
            sb_err_q <= sb_err_q;
        end
    end

    // Busy view of the registered counters.
    always_comb begin
        busy_vec = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            busy_vec[i] = (cnt_s[i] != CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations queued at drive time, checked mid-cycle.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_rs1_used;
    logic        de_rs2_used;
    logic        de_wr_reg;
    logic [4:0]  de_rd;
    logic        de_is_ctrl;
    logic        agex_ctrl_resolved;
    logic        wb_wr_reg;
    logic [4:0]  wb_rd;
    logic        issue;
    logic        stall_de;
    logic        stall_fe;
    logic [31:0] busy_vec;
    logic        sb_err;

    typedef struct {
        string       tag;
        logic [35:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    hazard_scoreboard dut (
        .clk                (clk),
        .reset              (reset),
        .de_valid           (de_valid),
        .de_rs1             (de_rs1),
        .de_rs2             (de_rs2),
        .de_rs1_used        (de_rs1_used),
        .de_rs2_used        (de_rs2_used),
        .de_wr_reg          (de_wr_reg),
        .de_rd              (de_rd),
        .de_is_ctrl         (de_is_ctrl),
        .agex_ctrl_resolved (agex_ctrl_resolved),
        .wb_wr_reg          (wb_wr_reg),
        .wb_rd              (wb_rd),
        .issue              (issue),
        .stall_de           (stall_de),
        .stall_fe           (stall_fe),
        .busy_vec           (busy_vec),
        .sb_err             (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bit_of(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    task automatic clr();
        de_valid = 1'b0; de_rs1 = 5'd0; de_rs2 = 5'd0; de_rs1_used = 1'b0;
        de_rs2_used = 1'b0; de_wr_reg = 1'b0; de_rd = 5'd0; de_is_ctrl = 1'b0;
        agex_ctrl_resolved = 1'b0; wb_wr_reg = 1'b0; wb_rd = 5'd0;
    endtask

    // Queue the expectation for the inputs just driven, then check it mid-cycle.
    task automatic chk(input string tag, input logic e_iss, input logic e_sde,
                       input logic e_sfe, input logic [31:0] e_busy, input logic e_err);
        exp_t e;
        logic [35:0] obs;
        e.tag = tag;
        e.v   = {1'b0, e_iss, e_sde, e_sfe, e_busy, e_err};
        exp_q.push_back(e);
        #1;
        e   = exp_q.pop_front();
        obs = {1'b0, issue, stall_de, stall_fe, busy_vec, sb_err};
        n_cmp++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed {iss,sde,sfe,busy,err}=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    initial begin
        clr();
        reset = 1'b1;
        @(negedge clk);
        chk("reset", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        @(negedge clk); reset = 1'b0; de_valid = 1'b1; de_wr_reg = 1'b1; de_rd = 5'd5;
        chk("issue_add_x5", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); clr();
        chk("busy_x5", 1'b0, 1'b0, 1'b0, bit_of(5), 1'b0);
        @(negedge clk); de_valid = 1'b1; de_rs1 = 5'd5; de_rs1_used = 1'b1;
        chk("raw_stall_x5", 1'b0, 1'b1, 1'b1, bit_of(5), 1'b0);
        @(negedge clk); wb_wr_reg = 1'b1; wb_rd = 5'd5;
        chk("wb_same_cycle", 1'b1, 1'b0, 1'b0, bit_of(5), 1'b0);
        @(negedge clk); clr();
        chk("wb_clear_x5", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        @(negedge clk); de_valid = 1'b1; de_wr_reg = 1'b1; de_rd = 5'd3;
        chk("issue_x3", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); clr(); de_valid = 1'b1; de_wr_reg = 1'b1; de_rd = 5'd0;
        de_rs1_used = 1'b1; de_rs1 = 5'd0; de_rs2 = 5'd3;
        chk("x0_and_unused_rs2", 1'b1, 1'b0, 1'b0, bit_of(3), 1'b0);
        @(negedge clk); clr();
        chk("x0_never_busy", 1'b0, 1'b0, 1'b0, bit_of(3), 1'b0);
        @(negedge clk); de_valid = 1'b1; de_rs2 = 5'd3; de_rs2_used = 1'b1;
        chk("rs2_stall_x3", 1'b0, 1'b1, 1'b1, bit_of(3), 1'b0);
        @(negedge clk); clr(); wb_wr_reg = 1'b1; wb_rd = 5'd3;
        chk("wb_x3", 1'b0, 1'b0, 1'b0, bit_of(3), 1'b0);

        @(negedge clk); clr(); de_valid = 1'b1; de_is_ctrl = 1'b1;
        chk("beq_issue", 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); clr(); de_valid = 1'b1;
            chk("ctrl_wait_hold", 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
        end
        @(negedge clk); agex_ctrl_resolved = 1'b1;
        chk("resolve_cycle", 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
        @(negedge clk); agex_ctrl_resolved = 1'b0;
        chk("resume_after_resolve", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); clr(); agex_ctrl_resolved = 1'b1;
        chk("resolve_in_idle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); clr(); de_valid = 1'b1;
        chk("idle_after_stray_pulse", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk); clr(); de_valid = 1'b1; de_wr_reg = 1'b1; de_rd = 5'd7;
            chk("fill_x7", 1'b1, 1'b0, 1'b0, (k == 0) ? 32'd0 : bit_of(7), 1'b0);
        end
        @(negedge clk);
        chk("x7_full_stall", 1'b0, 1'b1, 1'b1, bit_of(7), 1'b0);
        @(negedge clk); wb_wr_reg = 1'b1; wb_rd = 5'd7;
        chk("x7_full_wb_same", 1'b0, 1'b1, 1'b1, bit_of(7), 1'b0);
        @(negedge clk); wb_wr_reg = 1'b0;
        chk("x7_issue_after_wb", 1'b1, 1'b0, 1'b0, bit_of(7), 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); clr(); wb_wr_reg = 1'b1; wb_rd = 5'd7;
            chk("drain_x7", 1'b0, 1'b0, 1'b0, bit_of(7), 1'b0);
        end
        @(negedge clk); wb_rd = 5'd9;
        chk("underflow_x9_pre", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); clr();
        chk("sb_err_set", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("sb_err_sticky", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        @(negedge clk); de_valid = 1'b1; de_wr_reg = 1'b1; de_rd = 5'd3;
        chk("x3_first", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk); de_is_ctrl = 1'b1;
        chk("x3_second_ctrl", 1'b1, 1'b0, 1'b1, bit_of(3), 1'b1);
        @(negedge clk); clr(); de_valid = 1'b1; reset = 1'b1;
        chk("pre_reset_wait", 1'b0, 1'b1, 1'b1, bit_of(3), 1'b1);
        @(negedge clk); clr(); reset = 1'b0;
        chk("post_reset_clear", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); de_valid = 1'b1; de_wr_reg = 1'b1; de_rd = 5'd3; de_rs1 = 5'd3;
        de_rs1_used = 1'b1;
        chk("post_reset_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

        @(negedge clk); clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
